code_entry_ctrl: RTL and testbench

- Sequences the keypad datapath for the CodeBreak game.
- Consumes one-cycle key strobes from the keypad scanner/decoder and assembles a DIGITS-long guess, which also feeds the seven-segment display.
- On Enter, compares the guess against the secret code and reports exact-position hits, match or fail.
- Counts failed attempts and enforces a timed lockout after MAX_TRIES failures.

---
 rtl/code_entry_if.sv | 18 +
 rtl/code_entry_ctrl.sv | 119 +++++++++++
 tb/tb_code_entry_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/code_entry_if.sv
// code_entry_if: keypad strobe, secret code and guess/status bundle for code_entry_ctrl
interface code_entry_if #(parameter int DIGITS = 4);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   secret;
    logic [4*DIGITS-1:0]   entry;
    logic [2:0]            entry_len;
    logic [2:0]            hits;
    logic                  match;
    logic                  fail;
    logic [3:0]            tries;
    logic                  locked;
    logic                  solved;
    modport master(output key_valid, key_code, secret,
                   input entry, entry_len, hits, match, fail, tries, locked, solved);
    modport slave(input key_valid, key_code, secret,
                  output entry, entry_len, hits, match, fail, tries, locked, solved);
endinterface

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: assembles a keypad guess, checks it against the secret and enforces a timed lockout
module code_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int MAX_TRIES   = 7,
    parameter int LOCK_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    code_entry_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {ENTRY, CHECK, SOLVED, LOCKOUT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    entry_q, entry_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      hits_q, hits_d;
    logic [3:0]      tries_q, tries_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            match_q, match_d;
    logic            fail_q, fail_d;
    logic [2:0]      nhits;

    always_comb begin
        nhits = '0;
        for (int i = 0; i < DIGITS; i++)
            nhits = nhits + {2'b0, entry_q[4*i+:4] == bus.secret[4*i+:4]};
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        len_d   = len_q;
        hits_d  = hits_q;
        tries_d = tries_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            ENTRY: if (bus.key_valid) begin
                if (bus.key_code <= 4'd9) begin
                    if (len_q != 3'(DIGITS)) begin
                        entry_d = {entry_q[W-5:0], bus.key_code};
                        len_d   = len_q + 3'd1;
                    end
                end else if (bus.key_code == 4'hB) begin
                    if (len_q != 3'd0) begin
                        entry_d = entry_q >> 4;
                        len_d   = len_q - 3'd1;
                    end
                end else if (bus.key_code == 4'hC) begin
                    entry_d = '0;
                    len_d   = '0;
                end else if (bus.key_code == 4'hE && len_q == 3'(DIGITS)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                hits_d = nhits;
                if (nhits == 3'(DIGITS)) begin
                    match_d = 1'b1;
                    state_d = SOLVED;
                end else begin
                    fail_d  = 1'b1;
                    entry_d = '0;
                    len_d   = '0;
                    tries_d = tries_q + 4'd1;
                    state_d = (tries_d == 4'(MAX_TRIES)) ? LOCKOUT : ENTRY;
                    cnt_d   = (tries_d == 4'(MAX_TRIES)) ? CW'(LOCK_CYCLES - 1) : cnt_q;
                end
            end
            SOLVED: if (bus.key_valid && bus.key_code == 4'hC) begin
                entry_d = '0;
                len_d   = '0;
                tries_d = '0;
                hits_d  = '0;
                state_d = ENTRY;
            end
            LOCKOUT: begin
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                tries_d = (cnt_q == '0) ? 4'd0 : tries_q;
                state_d = (cnt_q == '0) ? ENTRY : LOCKOUT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTRY;
            entry_q <= '0;
            len_q   <= '0;
            hits_q  <= '0;
            tries_q <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            len_q   <= len_d;
            hits_q  <= hits_d;
            tries_q <= tries_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.entry     = entry_q;
    assign bus.entry_len = len_q;
    assign bus.hits      = hits_q;
    assign bus.match     = match_q;
    assign bus.fail      = fail_q;
    assign bus.tries     = tries_q;
    assign bus.locked    = state_q == LOCKOUT;
    assign bus.solved    = state_q == SOLVED;
endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb_code_entry_ctrl: table-driven key vectors plus lockout and reset corner sequences
module tb_code_entry_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_entry_if #(.DIGITS(4)) bus();
    code_entry_ctrl #(.DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(20)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        kv;
        logic [3:0]  key;
        logic [29:0] exp;
    } vec_t;

    vec_t vq[$];
    int   pass_n = 0;
    int   total_n = 0;

    wire [29:0] obs = {bus.entry, bus.entry_len, bus.hits, bus.match, bus.fail, bus.tries, bus.locked, bus.solved};

    function automatic logic [29:0] ex(input logic [15:0] e, input logic [2:0] n, input logic [2:0] h,
                                       input logic m, input logic f, input logic [3:0] t,
                                       input logic l, input logic s);
        return {e, n, h, m, f, t, l, s};
    endfunction

    task automatic add(input logic kv, input logic [3:0] k, input logic [29:0] e);
        vec_t v;
        v.kv = kv;
        v.key = k;
        v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [29:0] e);
        total_n++;
        if (obs === e) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, obs, e);
    endtask

    task automatic step(input logic kv, input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = kv;
        bus.key_code  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic wrong_guess();
        repeat (4) step(1'b1, 4'h9);
        step(1'b1, 4'hE);
        step(1'b0, 4'h0);
    endtask

    task automatic pulse_rst(input string nm);
        @(negedge clk);
        rst = 1'b1;
        bus.key_valid = 1'b0;
        @(posedge clk);
        #1;
        chk(nm, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.secret    = 16'h1234;
        // plan 1: solve, ignore extra digit; then clear from SOLVED
        add(1, 4'h1, ex(16'h0001, 1, 0, 0, 0, 0, 0, 0));
        add(1, 4'h2, ex(16'h0012, 2, 0, 0, 0, 0, 0, 0));
        add(1, 4'h3, ex(16'h0123, 3, 0, 0, 0, 0, 0, 0));
        add(1, 4'h4, ex(16'h1234, 4, 0, 0, 0, 0, 0, 0));
        add(1, 4'hE, ex(16'h1234, 4, 0, 0, 0, 0, 0, 0));
        add(0, 4'h0, ex(16'h1234, 4, 4, 1, 0, 0, 0, 1));
        add(1, 4'h5, ex(16'h1234, 4, 4, 0, 0, 0, 0, 1));
        add(1, 4'hC, ex(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        // plan 2: overflow, backspace, empty enter
        add(1, 4'h5, ex(16'h0005, 1, 0, 0, 0, 0, 0, 0));
        add(1, 4'hA, ex(16'h0005, 1, 0, 0, 0, 0, 0, 0));
        add(1, 4'h6, ex(16'h0056, 2, 0, 0, 0, 0, 0, 0));
        add(1, 4'h7, ex(16'h0567, 3, 0, 0, 0, 0, 0, 0));
        add(1, 4'h8, ex(16'h5678, 4, 0, 0, 0, 0, 0, 0));
        add(1, 4'h9, ex(16'h5678, 4, 0, 0, 0, 0, 0, 0));
        add(1, 4'hB, ex(16'h0567, 3, 0, 0, 0, 0, 0, 0));
        add(1, 4'hB, ex(16'h0056, 2, 0, 0, 0, 0, 0, 0));
        add(1, 4'hB, ex(16'h0005, 1, 0, 0, 0, 0, 0, 0));
        add(1, 4'hB, ex(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(1, 4'hB, ex(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(1, 4'hE, ex(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        add(0, 4'h0, ex(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        // plan 3: wrong guess 1939 -> 2 hits, then C keeps hits
        add(1, 4'h1, ex(16'h0001, 1, 0, 0, 0, 0, 0, 0));
        add(1, 4'h9, ex(16'h0019, 2, 0, 0, 0, 0, 0, 0));
        add(1, 4'h3, ex(16'h0193, 3, 0, 0, 0, 0, 0, 0));
        add(1, 4'h9, ex(16'h1939, 4, 0, 0, 0, 0, 0, 0));
        add(1, 4'hE, ex(16'h1939, 4, 0, 0, 0, 0, 0, 0));
        add(0, 4'h0, ex(16'h0000, 0, 2, 0, 1, 1, 0, 0));
        add(0, 4'h0, ex(16'h0000, 0, 2, 0, 0, 1, 0, 0));
        add(1, 4'hC, ex(16'h0000, 0, 2, 0, 0, 1, 0, 0));
        // plan 5: solve again, then C from SOLVED clears tries and hits
        add(1, 4'h1, ex(16'h0001, 1, 2, 0, 0, 1, 0, 0));
        add(1, 4'h2, ex(16'h0012, 2, 2, 0, 0, 1, 0, 0));
        add(1, 4'h3, ex(16'h0123, 3, 2, 0, 0, 1, 0, 0));
        add(1, 4'h4, ex(16'h1234, 4, 2, 0, 0, 1, 0, 0));
        add(1, 4'hE, ex(16'h1234, 4, 2, 0, 0, 1, 0, 0));
        add(0, 4'h0, ex(16'h1234, 4, 4, 1, 0, 1, 0, 1));
        add(0, 4'h0, ex(16'h1234, 4, 4, 0, 0, 1, 0, 1));
        add(1, 4'hC, ex(16'h0000, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset", '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].kv, vq[i].key);
            chk($sformatf("vec%0d", i), vq[i].exp);
        end

        // plan 4: lockout after three failures
        wrong_guess();
        chk("fail1", ex(16'h0, 0, 0, 0, 1, 1, 0, 0));
        wrong_guess();
        chk("fail2", ex(16'h0, 0, 0, 0, 1, 2, 0, 0));
        wrong_guess();
        chk("fail3_lock", ex(16'h0, 0, 0, 0, 1, 3, 1, 0));
        n = 0;
        while (bus.locked && n < 100) begin
            n++;
            step(1'b1, 4'h5);
        end
        total_n++;
        if (n == 20) pass_n++;
        else $display("FAIL lock_len: got %0d expected 20", n);
        chk("unlock", ex(16'h0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b1, 4'h3);
        chk("post_lock_digit", ex(16'h0003, 1, 0, 0, 0, 0, 0, 0));

        // plan 6: reset during LOCKOUT
        step(1'b1, 4'hC);
        repeat (3) wrong_guess();
        chk("relock", ex(16'h0, 0, 0, 0, 1, 3, 1, 0));
        repeat (3) step(1'b0, 4'h0);
        pulse_rst("rst_lockout");
        step(1'b0, 4'h0);
        chk("after_rst_lockout", '0);

        // plan 6: reset during the CHECK cycle of a correct guess
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, 4'h3);
        step(1'b1, 4'h4);
        step(1'b1, 4'hE);
        chk("pre_check", ex(16'h1234, 4, 0, 0, 0, 0, 0, 0));
        pulse_rst("rst_check");
        step(1'b0, 4'h0);
        chk("after_rst_check", '0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
